// File: rtl/ksa_serial_add64.sv
// Slice-serial adder: WIDTH-bit A+B+cin computed SLICE_W bits per cycle behind a valid/ready handshake.
// Define KSA_SERIAL_OVF_EN to add the signed-overflow output ovf.
module ksa_serial_add64 #(
  parameter int WIDTH   = 64,
  parameter int SLICE_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef KSA_SERIAL_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int SW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int IW     = SW + 1;
  localparam logic [IW-1:0] LAST = IW'(NSLICE);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_reg, state_next;
  logic [WIDTH-1:0]  a_reg, b_reg, sum_reg;
  logic              carry_reg, cout_reg;
  logic [IW-1:0]     idx_reg;
`ifdef KSA_SERIAL_OVF_EN
  logic              ovf_reg;
`endif

  logic [SLICE_W-1:0] a_sl [NSLICE];
  logic [SLICE_W-1:0] b_sl [NSLICE];
  logic [SW-1:0]      sel;
  logic [SLICE_W:0]   slice_res;
  logic               finishing;

  generate
    for (genvar gi = 0; gi < NSLICE; gi++) begin : g_slice
      assign a_sl[gi] = a_reg[gi*SLICE_W +: SLICE_W];
      assign b_sl[gi] = b_reg[gi*SLICE_W +: SLICE_W];
    end
  endgenerate

  assign sel       = idx_reg[SW-1:0];
  assign slice_res = {1'b0, a_sl[sel]} + {1'b0, b_sl[sel]} + {{SLICE_W{1'b0}}, carry_reg};
  // The cycle after the last slice publishes cout/ovf, so all results change together.
  assign finishing = (idx_reg == LAST);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid)  state_next = RUN;
      RUN:     if (finishing) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      idx_reg   <= '0;
`ifdef KSA_SERIAL_OVF_EN
      ovf_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= a;
            b_reg     <= b;
            carry_reg <= cin;
            idx_reg   <= '0;
          end
        end
        RUN: begin
          if (!finishing) begin
            sum_reg[sel*SLICE_W +: SLICE_W] <= slice_res[SLICE_W-1:0];
            carry_reg <= slice_res[SLICE_W];
            idx_reg   <= idx_reg + IW'(1);
          end else begin
            cout_reg <= carry_reg;
`ifdef KSA_SERIAL_OVF_EN
            // Carry into the MSB is recovered from the MSB's own sum bit.
            ovf_reg  <= a_reg[WIDTH-1] ^ b_reg[WIDTH-1] ^ sum_reg[WIDTH-1] ^ carry_reg;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign sum       = sum_reg;
  assign cout      = cout_reg;
`ifdef KSA_SERIAL_OVF_EN
  assign ovf       = ovf_reg;
`endif

endmodule

// File: tb/tb_ksa_serial_add64.sv
// Directed and random checks of ksa_serial_add64 against a plain 65-bit arithmetic model.
// Honours KSA_SERIAL_OVF_EN the same way as the design.
module tb_ksa_serial_add64;

  localparam int WIDTH   = 64;
  localparam int SLICE_W = 16;
  localparam int LAT     = WIDTH / SLICE_W + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a, b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef KSA_SERIAL_OVF_EN
  logic             ovf;
`endif

  int checks = 0;
  int errors = 0;

  ksa_serial_add64 #(.WIDTH(WIDTH), .SLICE_W(SLICE_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef KSA_SERIAL_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic scramble();
    a   = {$urandom, $urandom};
    b   = {$urandom, $urandom};
    cin = 1'($urandom_range(0, 1));
  endtask

  // One full transaction: accept, scrambled inputs while running, hold in DONE, release.
  task automatic run_op(input string tag, input logic [63:0] ta, input logic [63:0] tbv,
                        input logic tc, input int hold);
    logic [64:0] full;
    logic        eovf;
    logic [63:0] s0;
    logic        c0;
    int          lat;
    full = {1'b0, ta} + {1'b0, tbv} + {64'd0, tc};
    eovf = (ta[63] == tbv[63]) && (full[63] != ta[63]);
    chk({tag, ".ready_before"}, 64'(in_ready), 64'd1);
    a = ta; b = tbv; cin = tc; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    scramble();
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
      scramble();
    end
    chk({tag, ".latency"}, 64'(lat), 64'(LAT));
    s0 = sum;
    c0 = cout;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      scramble();
      tick();
      chk({tag, ".hold_sum"}, sum, s0);
      chk({tag, ".hold_cout"}, 64'(cout), 64'(c0));
      chk({tag, ".hold_inready"}, 64'(in_ready), 64'd0);
      chk({tag, ".hold_valid"}, 64'(out_valid), 64'd1);
    end
    chk({tag, ".sum"}, sum, full[63:0]);
    chk({tag, ".cout"}, 64'(cout), 64'(full[64]));
`ifdef KSA_SERIAL_OVF_EN
    chk({tag, ".ovf"}, 64'(ovf), 64'(eovf));
`endif
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk({tag, ".release_valid"}, 64'(out_valid), 64'd0);
    chk({tag, ".release_idle"}, 64'(in_ready), 64'd1);
    $display("op %s a=%h b=%h cin=%0d -> sum=%h cout=%0d lat=%0d", tag, ta, tbv, tc, sum, cout, lat);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    tick();
    tick();
    chk("rst.in_ready", 64'(in_ready), 64'd1);
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.sum", sum, 64'd0);
    chk("rst.cout", 64'(cout), 64'd0);
`ifdef KSA_SERIAL_OVF_EN
    chk("rst.ovf", 64'(ovf), 64'd0);
`endif
    rst = 1'b0;
    tick();

    run_op("basic", 64'd998, 64'd128, 1'b0, 0);
    run_op("xslice", 64'hFAAAAAAAFAAAAAAA, 64'hFAAAAAAADBBBBBBB, 1'b0, 0);
    run_op("ripple", 64'hFFFFFFFFFFFFFFFF, 64'd0, 1'b1, 0);
    run_op("backpr", {$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 3);

    // Abort during the second RUN cycle.
    a = 64'd998; b = 64'd128; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort.in_ready", 64'(in_ready), 64'd1);
    chk("abort.out_valid", 64'(out_valid), 64'd0);
    chk("abort.sum", sum, 64'd0);
    chk("abort.cout", 64'(cout), 64'd0);
    $display("op abort: rst in RUN -> in_ready=%0d out_valid=%0d sum=%h", in_ready, out_valid, sum);
    run_op("after_abort", 64'd998, 64'd128, 1'b0, 1);

    run_op("ovf_pos", 64'h7FFFFFFFFFFFFFFF, 64'd1, 1'b0, 0);
    run_op("ovf_neg", 64'h8000000000000000, 64'h8000000000000000, 1'b0, 0);

    for (int n = 0; n < 20; n++) begin
      run_op($sformatf("rand%0d", n), {$urandom, $urandom}, {$urandom, $urandom},
             1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
